// File: rtl/pipeline_loader_ctrl.sv
// pipeline_loader_ctrl
// ---------------------------------------------------------------------------
// Byte-command front end that loads a program into instruction memory and
// controls a pipeline run (free run or single step).
//
// Commands are received in IDLE:
//   'L' N w0[31:24] w0[23:16] w0[15:8] w0[7:0] ...  load N words
//   'R'                                           reset pipeline, then run
//   'S'                                           single-step one cycle
//   'H' (only while running)                      abort the run
//
// Ports
//   clk                 rising-edge clock
//   i_rst_n             asynchronous active-low reset
//   i_rx_data/i_rx_valid command/data byte and its qualifier
//   i_halt_detected     pipeline reports a retired HALT
//   o_we_IF/o_inst_addr/o_instruction_data  instruction-memory write port
//   o_pipe_rst_n        active-low pipeline reset
//   o_halt              pipeline freeze (high = frozen)
//   o_state             current FSM state encoding (debug)
//   o_loaded            a complete program is resident
//   o_done / o_err      one-cycle run-end / protocol-error pulses
//   o_cycles            cycles executed in the last run (saturating)
//
// Handshake: i_rx_valid is a strobe with no back-pressure. A byte is consumed
// on every rising edge where i_rx_valid is high; a byte arriving in a state
// that does not accept data (WRITE, PIPE_RST, DONE) is dropped.
// ---------------------------------------------------------------------------
module pipeline_loader_ctrl #(
  parameter int unsigned NB_DATA         = 32,
  parameter int unsigned MAX_INSTR       = 64,
  parameter int unsigned BASE_ADDR       = 4,
  parameter int unsigned PIPE_RST_CYCLES = 2
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_halt_detected,
  output logic               o_we_IF,
  output logic [31:0]        o_inst_addr,
  output logic [NB_DATA-1:0] o_instruction_data,
  output logic               o_pipe_rst_n,
  output logic               o_halt,
  output logic [2:0]         o_state,
  output logic               o_loaded,
  output logic               o_done,
  output logic               o_err,
  output logic [31:0]        o_cycles
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GET_CNT   = 3'd1,
    ST_GET_BYTES = 3'd2,
    ST_WRITE     = 3'd3,
    ST_PIPE_RST  = 3'd4,
    ST_RUN       = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  localparam logic [7:0] CMD_LOAD  = 8'h4C;
  localparam logic [7:0] CMD_RUN   = 8'h52;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_ABORT = 8'h48;
  localparam logic [7:0] PR_LAST   = 8'(PIPE_RST_CYCLES - 1);

  state_t               state_q, state_d;
  logic                 started_q, started_d;
  logic                 step_q, step_d;
  logic                 run_mode_q, run_mode_d;  // 1: PIPE_RST -> RUN, 0: -> step
  logic                 loaded_q, loaded_d;
  logic                 err_q, err_d;
  logic [31:0]          cycles_q, cycles_d, cycles_inc;
  logic [NB_DATA-1:0]   word_q, word_d;
  logic [31:0]          addr_q, addr_d;
  logic [7:0]           n_q, n_d;
  logic [1:0]           byte_cnt_q, byte_cnt_d;
  logic [7:0]           word_cnt_q, word_cnt_d;
  logic [7:0]           pr_cnt_q, pr_cnt_d;
  logic                 rst_seen_q;

  // Next-state and datapath decisions
  always_comb begin
    state_d    = state_q;
    started_d  = started_q;
    step_d     = 1'b0;
    run_mode_d = run_mode_q;
    loaded_d   = loaded_q;
    err_d      = 1'b0;
    cycles_d   = cycles_q;
    word_d     = word_q;
    addr_d     = addr_q;
    n_d        = n_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    pr_cnt_d   = pr_cnt_q;
    cycles_inc = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;

    case (state_q)
      ST_IDLE: begin
        // step_q marks the single unfrozen cycle of a step; it counts as
        // an executed cycle and a HALT retiring in it ends the run.
        if (step_q) begin
          cycles_d = cycles_inc;
        end
        if (step_q && i_halt_detected) begin
          state_d = ST_DONE;
        end else if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: begin
              state_d   = ST_GET_CNT;
              loaded_d  = 1'b0;
              started_d = 1'b0;
            end
            CMD_RUN: begin
              if (!loaded_q) begin
                err_d = 1'b1;
              end else begin
                state_d    = ST_PIPE_RST;
                pr_cnt_d   = 8'd0;
                run_mode_d = 1'b1;
              end
            end
            CMD_STEP: begin
              if (!loaded_q) begin
                err_d = 1'b1;
              end else if (!started_q) begin
                state_d    = ST_PIPE_RST;
                pr_cnt_d   = 8'd0;
                run_mode_d = 1'b0;
              end else begin
                step_d = 1'b1;
              end
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      ST_GET_CNT: begin
        if (i_rx_valid) begin
          if ((i_rx_data == 8'd0) || ({24'd0, i_rx_data} > MAX_INSTR)) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            n_d        = i_rx_data;
            byte_cnt_d = 2'd0;
            word_cnt_d = 8'd0;
            state_d    = ST_GET_BYTES;
          end
        end
      end

      ST_GET_BYTES: begin
        if (i_rx_valid) begin
          // The first byte of each word clears the previous word.
          if (byte_cnt_q == 2'd0) begin
            word_d = {{(NB_DATA-8){1'b0}}, i_rx_data};
          end else begin
            word_d = {word_q[NB_DATA-9:0], i_rx_data};
          end
          if (byte_cnt_q == 2'd3) begin
            byte_cnt_d = 2'd0;
            addr_d     = BASE_ADDR + {22'd0, word_cnt_q, 2'b00};
            state_d    = ST_WRITE;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end

      ST_WRITE: begin
        if (word_cnt_q < (n_q - 8'd1)) begin
          word_cnt_d = word_cnt_q + 8'd1;
          state_d    = ST_GET_BYTES;
        end else begin
          loaded_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end

      ST_PIPE_RST: begin
        cycles_d  = 32'd0;
        started_d = 1'b1;
        if (pr_cnt_q == PR_LAST) begin
          if (run_mode_q) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
            step_d  = 1'b1;
          end
        end else begin
          pr_cnt_d = pr_cnt_q + 8'd1;
        end
      end

      ST_RUN: begin
        cycles_d = cycles_inc;
        // A retired HALT and an abort byte in the same cycle both lead to
        // the single DONE visit, so o_done still pulses once.
        if (i_halt_detected || (i_rx_valid && (i_rx_data == CMD_ABORT))) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        started_d = 1'b0;
        state_d   = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      started_q  <= 1'b0;
      step_q     <= 1'b0;
      run_mode_q <= 1'b0;
      loaded_q   <= 1'b0;
      err_q      <= 1'b0;
      cycles_q   <= 32'd0;
      word_q     <= '0;
      addr_q     <= 32'd0;
      n_q        <= 8'd0;
      byte_cnt_q <= 2'd0;
      word_cnt_q <= 8'd0;
      pr_cnt_q   <= 8'd0;
      rst_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      started_q  <= started_d;
      step_q     <= step_d;
      run_mode_q <= run_mode_d;
      loaded_q   <= loaded_d;
      err_q      <= err_d;
      cycles_q   <= cycles_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      n_q        <= n_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      pr_cnt_q   <= pr_cnt_d;
      rst_seen_q <= 1'b1;
    end
  end

  // The pipeline stays in reset while this block is in reset and is released
  // on the first clock edge afterwards (rst_seen_q).
  assign o_pipe_rst_n       = rst_seen_q && (state_q != ST_PIPE_RST);
  assign o_halt             = !((state_q == ST_RUN) || step_q);
  assign o_we_IF            = (state_q == ST_WRITE);
  assign o_inst_addr        = addr_q;
  assign o_instruction_data = word_q;
  assign o_state            = state_q;
  assign o_loaded           = loaded_q;
  assign o_done             = (state_q == ST_DONE);
  assign o_err              = err_q;
  assign o_cycles           = cycles_q;

endmodule

// File: tb/tb_pipeline_loader_ctrl.sv
// Testbench for pipeline_loader_ctrl: command table, directed run/step/reset
// sequences and randomized loads/runs against a behavioural model.
module tb_pipeline_loader_ctrl;

  localparam int unsigned NB_DATA         = 32;
  localparam int unsigned MAX_INSTR       = 64;
  localparam int unsigned BASE_ADDR       = 4;
  localparam int unsigned PIPE_RST_CYCLES = 2;

  // ---------------- clock / reset / DUT ----------------
  logic               clk = 1'b0;
  logic               rst_n;
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               halt_det;
  logic               we_if;
  logic [31:0]        inst_addr;
  logic [NB_DATA-1:0] instr_data;
  logic               pipe_rst_n;
  logic               halt;
  logic [2:0]         state;
  logic               loaded;
  logic               done;
  logic               err;
  logic [31:0]        cycles;

  always #5 clk = ~clk;

  pipeline_loader_ctrl #(
    .NB_DATA(NB_DATA), .MAX_INSTR(MAX_INSTR),
    .BASE_ADDR(BASE_ADDR), .PIPE_RST_CYCLES(PIPE_RST_CYCLES)
  ) dut (
    .clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .i_halt_detected(halt_det), .o_we_IF(we_if), .o_inst_addr(inst_addr),
    .o_instruction_data(instr_data), .o_pipe_rst_n(pipe_rst_n), .o_halt(halt),
    .o_state(state), .o_loaded(loaded), .o_done(done), .o_err(err),
    .o_cycles(cycles)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];   // {addr, data} of each expected memory write
  int halt_low, pipe_low, pipe_pulses, done_cnt, err_cnt;
  logic pipe_prev = 1'b0;

  // Behavioural model of the program/run status
  bit          model_started = 1'b0;
  logic [31:0] model_cycles  = 32'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: observes outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!halt) halt_low++;
      if (!pipe_rst_n) pipe_low++;
      if (!pipe_rst_n && pipe_prev) pipe_pulses++;
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (we_if) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected",
                   inst_addr, instr_data);
        end else begin
          check("write", {inst_addr, instr_data}, exp_q.pop_front());
        end
      end
    end
    pipe_prev = pipe_rst_n;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_counts();
    halt_low = 0; pipe_low = 0; pipe_pulses = 0; done_cnt = 0; err_cnt = 0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int max_cycles, input string name);
    int k = 0;
    while (state !== s && k < max_cycles) begin
      @(negedge clk);
      k++;
    end
    check(name, {61'd0, state}, {61'd0, s});
  endtask

  task automatic load_prog(input int n);
    logic [31:0] w;
    logic [31:0] a;
    clear_counts();
    send_byte(8'h4C);
    send_byte(8'(n));
    for (int k = 0; k < n; k++) begin
      w = $urandom;
      a = BASE_ADDR + 4 * k;
      exp_q.push_back({a, w});
      for (int j = 3; j >= 0; j--) send_byte(w[8*j +: 8]);
    end
    wait_cycles(3);
    check("load_all_written", 64'(exp_q.size()), 64'd0);
    check("load_loaded", {63'd0, loaded}, 64'd1);
    check("load_err", 64'(err_cnt), 64'd0);
    check("load_state", {61'd0, state}, 64'd0);
    model_started = 1'b0;
  endtask

  // mode 0: HALT retires, 1: 'H' abort, 2: both in the same cycle
  task automatic run_prog(input int m, input int mode);
    logic [7:0] junk;
    clear_counts();
    send_byte(8'h52);
    wait_state(3'd5, 20, "run_entry");
    for (int j = 1; j < m; j++) begin
      if (j == 1 && m >= 3) begin
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'h48) junk = 8'h00;
        rx_data  = junk;
        rx_valid = 1'b1;
      end
      @(negedge clk);
      rx_valid = 1'b0;
    end
    if (mode != 1) halt_det = 1'b1;
    if (mode != 0) begin
      rx_data  = 8'h48;
      rx_valid = 1'b1;
    end
    @(negedge clk);
    halt_det = 1'b0;
    rx_valid = 1'b0;
    wait_cycles(4);
    check("run_cycles", {32'd0, cycles}, 64'(m));
    check("run_halt_low", 64'(halt_low), 64'(m));
    check("run_pipe_low", 64'(pipe_low), 64'(PIPE_RST_CYCLES));
    check("run_done", 64'(done_cnt), 64'd1);
    check("run_err", 64'(err_cnt), 64'd0);
    check("run_state", {61'd0, state}, 64'd0);
    model_started = 1'b0;
  endtask

  task automatic do_steps(input int s);
    int exp_pulses;
    clear_counts();
    exp_pulses = model_started ? 0 : 1;
    if (!model_started) model_cycles = 32'd0;
    for (int i = 0; i < s; i++) begin
      send_byte(8'h53);
      wait_cycles(5);
      model_cycles++;
      model_started = 1'b1;
    end
    check("step_halt_low", 64'(halt_low), 64'(s));
    check("step_pipe_pulses", 64'(pipe_pulses), 64'(exp_pulses));
    check("step_cycles", {32'd0, cycles}, {32'd0, model_cycles});
    check("step_done", 64'(done_cnt), 64'd0);
    check("step_err", 64'(err_cnt), 64'd0);
    check("step_state", {61'd0, state}, 64'd0);
  endtask

  // HALT retiring during the single step cycle (requires started).
  task automatic step_with_halt();
    clear_counts();
    send_byte(8'h53);
    halt_det = 1'b1;
    @(negedge clk);
    halt_det = 1'b0;
    wait_cycles(4);
    model_cycles++;
    check("stephalt_done", 64'(done_cnt), 64'd1);
    check("stephalt_cycles", {32'd0, cycles}, {32'd0, model_cycles});
    check("stephalt_halt_low", 64'(halt_low), 64'd1);
    check("stephalt_state", {61'd0, state}, 64'd0);
    model_started = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_we"},    {63'd0, we_if},      64'd0);
    check({tag, "_addr"},  {32'd0, inst_addr},  64'd0);
    check({tag, "_data"},  64'(instr_data),     64'd0);
    check({tag, "_piperst"}, {63'd0, pipe_rst_n}, 64'd0);
    check({tag, "_halt"},  {63'd0, halt},       64'd1);
    check({tag, "_loaded"}, {63'd0, loaded},    64'd0);
    check({tag, "_done"},  {63'd0, done},       64'd0);
    check({tag, "_err"},   {63'd0, err},        64'd0);
    check({tag, "_cycles"}, {32'd0, cycles},    64'd0);
    check({tag, "_state"}, {61'd0, state},      64'd0);
  endtask

  // ---------------- command table ----------------
  typedef struct packed {
    logic [79:0] bytes;      // first byte in the most significant position
    logic [3:0]  len;
    logic [1:0]  exp_err;
    logic        exp_loaded;
  } vec_t;

  vec_t vecs [0:7];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        v;
    logic [7:0]  b0, b1;
    logic [31:0] a;
    int          n;

    vecs[0] = '{bytes: {8'h52, 72'd0}, len: 4'd1, exp_err: 2'd1, exp_loaded: 1'b0};
    vecs[1] = '{bytes: {8'h58, 72'd0}, len: 4'd1, exp_err: 2'd1, exp_loaded: 1'b0};
    vecs[2] = '{bytes: {8'h53, 72'd0}, len: 4'd1, exp_err: 2'd1, exp_loaded: 1'b0};
    vecs[3] = '{bytes: 80'h4C02_2000000F_FFFFFFFF, len: 4'd10, exp_err: 2'd0, exp_loaded: 1'b1};
    vecs[4] = '{bytes: {16'h4C00, 64'd0}, len: 4'd2, exp_err: 2'd1, exp_loaded: 1'b0};
    vecs[5] = '{bytes: {16'h4C41, 64'd0}, len: 4'd2, exp_err: 2'd1, exp_loaded: 1'b0};
    vecs[6] = '{bytes: {48'h4C01_12345678, 32'd0}, len: 4'd6, exp_err: 2'd0, exp_loaded: 1'b1};
    vecs[7] = '{bytes: {8'h5A, 72'd0}, len: 4'd1, exp_err: 2'd1, exp_loaded: 1'b1};

    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    halt_det = 1'b0;
    wait_cycles(2);
    check_reset_values("por");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("por_piperst_release", {63'd0, pipe_rst_n}, 64'd1);
    wait_cycles(1);

    // Command table
    for (int i = 0; i < 8; i++) begin
      v  = vecs[i];
      b0 = v.bytes[79:72];
      b1 = v.bytes[71:64];
      clear_counts();
      if (b0 == 8'h4C && v.len >= 4'd2 && b1 != 8'd0 && b1 <= MAX_INSTR) begin
        for (int k = 0; k < int'(b1); k++) begin
          a = BASE_ADDR + 4 * k;
          exp_q.push_back({a, v.bytes[63 - 32*k -: 32]});
        end
      end
      for (int j = 0; j < int'(v.len); j++) send_byte(v.bytes[79 - 8*j -: 8]);
      wait_cycles(3);
      check($sformatf("vec%0d_err", i), 64'(err_cnt), 64'(v.exp_err));
      check($sformatf("vec%0d_loaded", i), {63'd0, loaded}, {63'd0, v.exp_loaded});
      check($sformatf("vec%0d_state", i), {61'd0, state}, 64'd0);
      check($sformatf("vec%0d_writes", i), 64'(exp_q.size()), 64'd0);
    end
    model_started = 1'b0;

    // Run, steps, halt during step, load clears started
    run_prog(10, 0);
    do_steps(3);
    do_steps(1);
    step_with_halt();
    do_steps(2);
    load_prog(3);
    do_steps(1);
    run_prog(5, 2);
    run_prog(7, 1);

    // Reset in the middle of a load, then reload from scratch
    send_byte(8'h4C);
    send_byte(8'h02);
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("midload");
    wait_cycles(2);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midload_piperst_release", {63'd0, pipe_rst_n}, 64'd1);
    model_started = 1'b0;
    load_prog(2);

    // Randomized loads followed by a run or a burst of steps
    for (int it = 0; it < 5; it++) begin
      n = (it == 0) ? int'(MAX_INSTR) : $urandom_range(1, 12);
      load_prog(n);
      if ($urandom_range(0, 1) == 1) run_prog($urandom_range(1, 20), $urandom_range(0, 2));
      else do_steps($urandom_range(1, 4));
    end

    wait_cycles(3);
    check("final_no_pending_writes", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_loader_ctrl.md
PIPELINE_LOADER_CTRL -- requirements
Module: pipeline_loader_ctrl

Interface
REQ-001 SHALL have parameter NB_DATA, default 32, meaning instruction word width.
REQ-002 SHALL have parameter MAX_INSTR, default 64, meaning the maximum number of words per load.
REQ-003 SHALL have parameter BASE_ADDR, default 4, meaning the byte address of the first loaded word.
REQ-004 SHALL have parameter PIPE_RST_CYCLES, default 2, meaning the pipeline reset pulse length in cycles.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1, reset; it is asynchronous and active-low.
REQ-007 SHALL have port i_rx_data, input, 8, the command/data byte.
REQ-008 SHALL have port i_rx_valid, input, 1, a one-cycle strobe qualifying i_rx_data.
REQ-009 SHALL have port i_halt_detected, input, 1, asserted by the pipeline when a HALT instruction retires.
REQ-010 SHALL have port o_we_IF, output, 1, the instruction-memory write enable.
REQ-011 SHALL have port o_inst_addr, output, 32, the instruction-memory byte address.
REQ-012 SHALL have port o_instruction_data, output, NB_DATA, the instruction-memory write data.
REQ-013 SHALL have port o_pipe_rst_n, output, 1, the active-low pipeline reset.
REQ-014 SHALL have port o_halt, output, 1, which freezes the pipeline when high.
REQ-015 SHALL have port o_state, output, 3, the current FSM state encoding.
REQ-016 SHALL have port o_loaded, output, 1, set when a valid program is resident.
REQ-017 SHALL have port o_done, output, 1, a one-cycle pulse when a run ends.
REQ-018 SHALL have port o_err, output, 1, a one-cycle pulse on a protocol error.
REQ-019 SHALL have port o_cycles, output, 32, the number of cycles executed in the last run.

Function
REQ-020 SHALL implement states IDLE=0, GET_CNT=1, GET_BYTES=2, WRITE=3, PIPE_RST=4, RUN=5, DONE=6.
REQ-021 SHALL, in IDLE, decode i_rx_data when i_rx_valid is high: 0x4C 'L' goes to GET_CNT; 0x52 'R' goes to PIPE_RST; 0x53 'S' means step; any other byte pulses o_err and stays in IDLE.
REQ-022 SHALL, in GET_CNT, take the next valid byte as the word count N; N=0 or N>MAX_INSTR pulses o_err, returns to IDLE and leaves o_loaded unchanged.
REQ-023 SHALL clear o_loaded on entry to GET_CNT.
REQ-024 SHALL, in GET_BYTES, shift in bytes MSB first; on the 4th byte it goes to WRITE.
REQ-025 SHALL, in WRITE, assert o_we_IF for exactly 1 cycle with o_inst_addr=BASE_ADDR+4*k and o_instruction_data=the assembled word, where k is the 0-based word index.
REQ-026 SHALL return from WRITE to GET_BYTES if k<N-1.
REQ-027 SHALL, after WRITE of the last word, set o_loaded=1 and go to IDLE.
REQ-028 SHALL drop a byte arriving in the WRITE cycle; the bench must not send one there.
REQ-029 SHALL hold o_halt=1 in every state except RUN and the single step cycle.
REQ-030 SHALL, on 'R' or 'S' with o_loaded=0, pulse o_err and stay in IDLE.
REQ-031 SHALL, in PIPE_RST, drive o_pipe_rst_n=0 for PIPE_RST_CYCLES cycles, clear o_cycles and set an internal started flag.
REQ-032 SHALL leave PIPE_RST for RUN on 'R', or for IDLE on 'S' after 1 step cycle.
REQ-033 SHALL, in RUN, drive o_halt=0 and increment o_cycles every cycle, saturating at 0xFFFFFFFF.
REQ-034 SHALL exit RUN to DONE on i_halt_detected, or on a valid byte 0x48 'H' (abort); other bytes in RUN are ignored.
REQ-035 SHALL, in DONE, pulse o_done for 1 cycle, clear started and go to IDLE.
REQ-036 SHALL, on 'S' with started=0, pass through PIPE_RST first.
REQ-037 SHALL, on 'S' with started=1, drive o_halt=0 for exactly 1 cycle, increment o_cycles and stay in IDLE.
REQ-038 SHALL treat i_halt_detected during a step cycle as DONE.
REQ-039 SHALL give i_halt_detected priority over a simultaneous 'H'; o_done pulses once.
REQ-040 SHALL, on 'L' received while started=1, clear started, so the next 'R' resets the pipeline.

Reset
REQ-041 SHALL, on i_rst_n=0, immediately force: state IDLE, o_we_IF=0, o_inst_addr=0, o_instruction_data=0, o_pipe_rst_n=0, o_halt=1, o_loaded=0, o_done=0, o_err=0, o_cycles=0, started=0, byte and word counters 0.
REQ-042 SHALL drive o_pipe_rst_n=1 from the first clock edge after reset release.
REQ-043 SHALL abort any load or run on reset mid-operation, with no partial write issued afterwards.

Verification
REQ-044 SHALL be covered by: 'L',0x02,20 00 00 0F,FF FF FF FF -> two o_we_IF pulses at addr 0x4 (data 0x2000000F) and 0x8 (data 0xFFFFFFFF), then o_loaded=1 and state=0.
REQ-045 SHALL be covered by: 'L',0x00 and 'L',0x41 -> o_err pulse each time, no o_we_IF, o_loaded=0.
REQ-046 SHALL be covered by: load, then 'R', with i_halt_detected raised 10 cycles after RUN entry -> o_pipe_rst_n low 2 cycles, o_halt low 10 cycles, o_done 1 cycle, o_cycles=10.
REQ-047 SHALL be covered by: load, then 'S' three times -> exactly three single-cycle o_halt=0 windows, one o_pipe_rst_n pulse, o_cycles=3.
REQ-048 SHALL be covered by: 'R' with no program loaded, then 'X' -> o_err pulse for each, state stays IDLE.
REQ-049 SHALL be covered by: i_rst_n driven low during GET_BYTES after 2 bytes, then a full reload -> all outputs at reset values, and the reload writes the correct words starting at addr 0x4.
